// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional performance counters are enabled with `define SEQ_PERF_EN.

`ifndef MEM_NONE
`define MEM_NONE    4'd0
`define MEM_LOAD1   4'd1
`define MEM_LOAD2   4'd2
`define MEM_LOAD4   4'd3
`define MEM_LOADU1  4'd4
`define MEM_LOADU2  4'd5
`define MEM_STORE1  4'd6
`define MEM_STORE2  4'd7
`define MEM_STORE4  4'd8
`endif

module core_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        ir_we_o,
    input  logic [3:0]  mem_ctrl_i,
    input  logic        reg_w_en_i,
    input  logic        csr_we_i,
    input  logic        ebreak_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    output logic        pc_we_o,
    output logic        rf_we_o,
    output logic        csr_we_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [2:0]  state_o
`ifdef SEQ_PERF_EN
    ,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    // A zero MEM_TIMEOUT still needs a 1-bit counter to keep the logic legal.
    localparam int CW = (MEM_TIMEOUT > 32'sd0) ? $clog2(MEM_TIMEOUT + 32'sd1) : 32'sd1;
    localparam bit TMO_EN = (MEM_TIMEOUT > 32'sd0);
    localparam logic [CW-1:0] LAST_C = CW'(MEM_TIMEOUT - 32'sd1);
    localparam logic [CW-1:0] ONE_C  = CW'(32'd1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   tmo_cnt_r;
    logic            tmo_hit_s;
    logic            is_store_s;

    assign tmo_hit_s  = TMO_EN && (tmo_cnt_r == LAST_C);
    assign is_store_s = (mem_ctrl_i == `MEM_STORE1) || (mem_ctrl_i == `MEM_STORE2) ||
                        (mem_ctrl_i == `MEM_STORE4);
    assign ir_we_o    = (state_r == ST_FETCH) && imem_ready_i;
    assign state_o    = state_r;

    // Next-state selection; a ready in the timeout cycle takes priority over the fault.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   if (start_i) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
            ST_FETCH:  if (imem_ready_i) state_nxt_s = ST_DECODE; else state_nxt_s = ST_FETCH;
            ST_DECODE: if (ebreak_i) state_nxt_s = ST_HALT; else state_nxt_s = ST_EXEC;
            ST_EXEC:   if (mem_ctrl_i != `MEM_NONE) state_nxt_s = ST_MEM; else state_nxt_s = ST_WB;
            ST_MEM: begin
                if (dmem_ready_i)   state_nxt_s = ST_WB;
                else if (tmo_hit_s) state_nxt_s = ST_FAULT;
                else                state_nxt_s = ST_MEM;
            end
            ST_WB:     if (start_i) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
            ST_HALT:   state_nxt_s = ST_HALT;
            ST_FAULT:  state_nxt_s = ST_FAULT;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, MEM wait counter and Moore strobes registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= '0;
            imem_req_o <= 1'b0;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            pc_we_o    <= 1'b0;
            rf_we_o    <= 1'b0;
            csr_we_o   <= 1'b0;
            halted_o   <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_MEM) && !dmem_ready_i) begin
                tmo_cnt_r <= tmo_cnt_r + ONE_C;
            end else begin
                tmo_cnt_r <= '0;
            end
            imem_req_o <= (state_nxt_s == ST_FETCH);
            dmem_req_o <= (state_nxt_s == ST_MEM);
            dmem_we_o  <= (state_nxt_s == ST_MEM) && is_store_s;
            pc_we_o    <= (state_nxt_s == ST_WB);
            rf_we_o    <= (state_nxt_s == ST_WB) && reg_w_en_i;
            csr_we_o   <= (state_nxt_s == ST_WB) && csr_we_i;
            halted_o   <= (state_nxt_s == ST_HALT);
            fault_o    <= (state_nxt_s == ST_FAULT);
        end
    end

`ifdef SEQ_PERF_EN
    // Active-cycle and retired-instruction counters, free-running modulo 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_o <= 64'd0;
            instret_o   <= 64'd0;
        end else begin
            if ((state_r >= ST_FETCH) && (state_r <= ST_WB)) begin
                cycle_cnt_o <= cycle_cnt_o + 64'd1;
            end else begin
                cycle_cnt_o <= cycle_cnt_o;
            end
            if (state_r == ST_WB) begin
                instret_o <= instret_o + 64'd1;
            end else begin
                instret_o <= instret_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl (MEM_TIMEOUT = 16).
// Performance counter checks run only when SEQ_PERF_EN is defined.

module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        imem_req_o;
    logic        imem_ready_i;
    logic        ir_we_o;
    logic [3:0]  mem_ctrl_i;
    logic        reg_w_en_i;
    logic        csr_we_i;
    logic        ebreak_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ready_i;
    logic        pc_we_o;
    logic        rf_we_o;
    logic        csr_we_o;
    logic        halted_o;
    logic        fault_o;
    logic [2:0]  state_o;
`ifdef SEQ_PERF_EN
    logic [63:0] cycle_cnt_o;
    logic [63:0] instret_o;
`endif

    localparam logic [3:0] MC_NONE   = 4'd0;
    localparam logic [3:0] MC_LOAD4  = 4'd3;
    localparam logic [3:0] MC_STORE4 = 4'd8;

    int total = 0;
    int bad   = 0;

    core_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .imem_req_o   (imem_req_o),
        .imem_ready_i (imem_ready_i),
        .ir_we_o      (ir_we_o),
        .mem_ctrl_i   (mem_ctrl_i),
        .reg_w_en_i   (reg_w_en_i),
        .csr_we_i     (csr_we_i),
        .ebreak_i     (ebreak_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_ready_i (dmem_ready_i),
        .pc_we_o      (pc_we_o),
        .rf_we_o      (rf_we_o),
        .csr_we_o     (csr_we_o),
        .halted_o     (halted_o),
        .fault_o      (fault_o),
        .state_o      (state_o)
`ifdef SEQ_PERF_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instret_o    (instret_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] alu_seq [4];
        int req_cnt;
        int we_cnt;
        int pc_seen;
        int n;
        alu_seq[0] = 3'd1; alu_seq[1] = 3'd2; alu_seq[2] = 3'd3; alu_seq[3] = 3'd5;

        rst_n = 1'b0; start_i = 1'b0; imem_ready_i = 1'b0; mem_ctrl_i = MC_NONE;
        reg_w_en_i = 1'b0; csr_we_i = 1'b0; ebreak_i = 1'b0; dmem_ready_i = 1'b0;
        #2;
        chk("rst_state", state_o, 3'd0);
        chk("rst_imem_req", imem_req_o, 1'b0);
        chk("rst_pc_we", pc_we_o, 1'b0);
        chk("rst_halt_fault", {halted_o, fault_o}, 2'b00);
`ifdef SEQ_PERF_EN
        chk("rst_cycle_cnt", cycle_cnt_o, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI stream with instant fetch
        start_i = 1'b1; imem_ready_i = 1'b1; reg_w_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alu_state", state_o, alu_seq[i % 4]);
            chk("alu_pc_we", pc_we_o, alu_seq[i % 4] == 3'd5);
            chk("alu_rf_we", rf_we_o, alu_seq[i % 4] == 3'd5);
            chk("alu_imem_req", imem_req_o, alu_seq[i % 4] == 3'd1);
            chk("alu_ir_we", ir_we_o, alu_seq[i % 4] == 3'd1);
            chk("alu_dmem_req", dmem_req_o, 1'b0);
        end
        start_i = 1'b0;
        tick();
        chk("park_state", state_o, 3'd0);
        chk("park_imem_req", imem_req_o, 1'b0);

        // CSR instruction with start dropped mid-instruction
        start_i = 1'b1; reg_w_en_i = 1'b0; csr_we_i = 1'b1;
        tick();
        chk("csr_fetch", state_o, 3'd1);
        start_i = 1'b0;
        tick();
        chk("csr_decode", state_o, 3'd2);
        tick();
        chk("csr_exec", state_o, 3'd3);
        tick();
        chk("csr_wb_state", state_o, 3'd5);
        chk("csr_wb_strobes", {pc_we_o, rf_we_o, csr_we_o}, 3'b101);
        tick();
        chk("csr_park", state_o, 3'd0);
        chk("csr_we_clear", csr_we_o, 1'b0);
        csr_we_i = 1'b0;

        // LW with three wait cycles
        mem_ctrl_i = MC_LOAD4; reg_w_en_i = 1'b1; start_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        tick();
        chk("lw_exec", state_o, 3'd3);
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lw_mem_state", state_o, 3'd4);
            chk("lw_dmem_we", dmem_we_o, 1'b0);
            chk("lw_pc_we_mem", pc_we_o, 1'b0);
            if (dmem_req_o) req_cnt++;
            if (i == 3) dmem_ready_i = 1'b1;
        end
        tick();
        dmem_ready_i = 1'b0;
        chk("lw_req_cycles", req_cnt, 4);
        chk("lw_wb_state", state_o, 3'd5);
        chk("lw_wb_strobes", {pc_we_o, rf_we_o, dmem_req_o}, 3'b110);
        tick();
        chk("lw_park", state_o, 3'd0);

        // SW that never completes: timeout fault
        mem_ctrl_i = MC_STORE4; start_i = 1'b1;
        tick(); tick(); tick();
        we_cnt = 0; pc_seen = 0; n = 0;
        while (!fault_o && n < 60) begin
            tick();
            n++;
            if (dmem_we_o) we_cnt++;
            if (pc_we_o) pc_seen++;
        end
        chk("sw_we_cycles", we_cnt, 16);
        chk("sw_fault", fault_o, 1'b1);
        chk("sw_fault_state", state_o, 3'd7);
        chk("sw_no_pc_we", pc_seen, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sw_fault_sticky", {fault_o, imem_req_o, pc_we_o, dmem_req_o}, 4'b1000);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("sw_rst_fault", fault_o, 1'b0);
        chk("sw_rst_state", state_o, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a MEM wait, then restart
        mem_ctrl_i = MC_LOAD4; start_i = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("mrst_in_mem", {state_o, dmem_req_o}, {3'd4, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req_drop", dmem_req_o, 1'b0);
        chk("mrst_state", state_o, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst_refetch", {state_o, imem_req_o}, {3'd1, 1'b1});
        start_i = 1'b0;
        do_reset();

        // EBREAK after a stalled fetch
        mem_ctrl_i = MC_NONE; start_i = 1'b1; imem_ready_i = 1'b0; ebreak_i = 1'b1;
        tick();
        chk("eb_fetch_wait", {state_o, ir_we_o}, {3'd1, 1'b0});
        tick();
        chk("eb_fetch_hold", {state_o, imem_req_o}, {3'd1, 1'b1});
        imem_ready_i = 1'b1;
        #1;
        chk("eb_ir_we_mealy", ir_we_o, 1'b1);
        tick();
        chk("eb_decode", state_o, 3'd2);
        tick();
        chk("eb_halt", {state_o, halted_o}, {3'd6, 1'b1});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eb_halt_sticky", {halted_o, imem_req_o, pc_we_o, rf_we_o}, 4'b1000);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("eb_rst_clear", {halted_o, state_o}, {1'b0, 3'd0});
        ebreak_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_PERF_EN
        // Ten zero-wait ALU instructions
        do_reset();
        start_i = 1'b1; imem_ready_i = 1'b1; mem_ctrl_i = MC_NONE;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 40) start_i = 1'b0;
        end
        tick();
        chk("perf_idle", state_o, 3'd0);
        chk("perf_instret", instret_o, 64'd10);
        chk("perf_cycles", cycle_cnt_o, 64'd40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
